// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: arctangent table, pi, gain and FSM states.
// Macro CORDIC_GAIN_COMP_EN adds the SCALE state used for gain compensation.
package cordic_pkg;

    // Angles are scaled at 2^29 counts per radian, which is the 32-bit angle scale.
    localparam logic signed [31:0] PI      = 32'sd1686629713;
    localparam logic signed [31:0] PI_HALF = PI >>> 1;

    localparam logic [15:0] CORDIC_GAIN = 16'h26DD;
    localparam int          GAIN_SHIFT  = 14;

    // atan(2^-i) for i = 0..30; entry 31 pads the table to a 5-bit index.
    localparam logic signed [31:0] ATAN_TABLE [32] = '{
        32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
        32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
        32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
        32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384,
        32'sd8192,      32'sd4096,      32'sd2048,      32'sd1024,
        32'sd512,       32'sd256,       32'sd128,       32'sd64,
        32'sd32,        32'sd16,        32'sd8,         32'sd4,
        32'sd2,         32'sd1,         32'sd1,         32'sd0
    };

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [1:0] {IDLE, CALC, SCALE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

endpackage

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: converts (x, y) into (magnitude, atan2 angle).
// Define CORDIC_GAIN_COMP_EN to add a SCALE step that removes the CORDIC gain.
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ITERATIONS  = 15,
    parameter int ANGLE_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [WIDTH-1:0]       x_start,
    input  logic signed [WIDTH-1:0]       y_start,
    output logic signed [WIDTH+1:0]       magnitude,
    output logic signed [ANGLE_WIDTH-1:0] angle,
    output logic                          busy,
    output logic                          done
);

    localparam int XW    = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    // Table constants live at 2^29 counts/radian; narrower angle ports (<= 32) drop LSBs.
    function automatic logic signed [ANGLE_WIDTH-1:0] to_angle(input logic signed [31:0] v);
        return ANGLE_WIDTH'(v >>> (32 - ANGLE_WIDTH));
    endfunction

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic signed [XW-1:0]          x_q, x_d, y_q, y_d;
    logic signed [ANGLE_WIDTH-1:0] z_q, z_d;
    logic                          zero_q, zero_d;
    logic signed [XW-1:0]          mag_q, mag_d;
    logic signed [ANGLE_WIDTH-1:0] ang_q, ang_d;

    logic signed [XW-1:0]          x_ext, y_ext, x_shift, y_shift;
    logic [4:0]                    atan_idx;
    logic signed [ANGLE_WIDTH-1:0] atan_i;

    assign x_ext    = {{2{x_start[WIDTH-1]}}, x_start};
    assign y_ext    = {{2{y_start[WIDTH-1]}}, y_start};
    assign x_shift  = x_q >>> cnt_q;
    assign y_shift  = y_q >>> cnt_q;
    assign atan_idx = 5'(cnt_q);
    assign atan_i   = to_angle(ATAN_TABLE[atan_idx]);

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [XW+16:0] prod;
    assign prod = x_q * $signed({1'b0, CORDIC_GAIN});
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    zero_d  = (x_start == '0) && (y_start == '0);
                    // Fold left half-plane into the right so the iterations converge.
                    if (x_ext[XW-1] && !y_ext[XW-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = to_angle(PI_HALF);
                    end else if (x_ext[XW-1]) begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -to_angle(PI_HALF);
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                end
            end
            CALC: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_shift;
                    y_d = y_q - x_shift;
                    z_d = z_q + atan_i;
                end else begin
                    x_d = x_q - y_shift;
                    y_d = y_q + x_shift;
                    z_d = z_q - atan_i;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = SCALE;
`else
                    state_d = DONE;
                    mag_d   = x_d;
                    ang_d   = zero_q ? '0 : z_d;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            SCALE: begin
                state_d = DONE;
                mag_d   = XW'(prod >>> GAIN_SHIFT);
                ang_d   = zero_q ? '0 : z_q;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            ang_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
        end
    end

    assign magnitude = mag_q;
    assign angle     = ang_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 Parameter WIDTH, default 16: coordinate width, Q(WIDTH-2) fixed point, so 1.0 = 2^(WIDTH-2).
REQ-002 Parameter ITERATIONS, default 15: micro-rotations, 1..WIDTH-1.
REQ-003 Parameter ANGLE_WIDTH, default 32: angle width, 2^(ANGLE_WIDTH-3) counts per radian.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request pulse, sampled only in IDLE.
REQ-007 x_start  in  WIDTH signed  vector X component.
REQ-008 y_start  in  WIDTH signed  vector Y component.
REQ-009 magnitude  out  WIDTH+2 signed  vector length, Q(WIDTH-2).
REQ-010 angle  out  ANGLE_WIDTH signed  atan2(y,x) in (-pi, +pi].
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle completion pulse.

Function
REQ-013 Vectoring-mode CORDIC: the block is the inverse of the team's rotation CORDIC; it converts (x,y) to (magnitude, angle).
REQ-014 FSM states are IDLE, CALC, SCALE (present only with the macro) and DONE.
REQ-015 IDLE->CALC on start=1; at that edge, capture inputs sign-extended to WIDTH+2 bits, clear the iteration counter, and apply pre-rotation.
REQ-016 Pre-rotation, x<0 and y>=0: x'=y, y'=-x, z=+pi/2. Pre-rotation, x<0 and y<0: x'=-y, y'=x, z=-pi/2. Otherwise x'=x, y'=y, z=0.
REQ-017 CALC iteration i with y>=0: x+=y>>>i, y-=x>>>i, z+=atan(2^-i). With y<0: subtract on x, add on y, z-=atan(2^-i). All updates use previous-cycle values and arithmetic shifts.
REQ-018 After iteration ITERATIONS-1, go to DONE, or to SCALE when the macro is defined; DONE->IDLE unconditionally after one cycle.
REQ-019 If start is sampled at edge k, done=1 for exactly one cycle after edge k+ITERATIONS, or edge k+ITERATIONS+1 with the macro.
REQ-020 Outputs update only on entry to DONE and hold until the next DONE.
REQ-021 start while busy=1 is ignored with no queuing; start in the DONE cycle is also ignored.
REQ-022 Input x=0 and y=0 yields magnitude=0 and angle=0 exactly.
REQ-023 Input (-x,0) yields angle +pi, never -pi; the most negative input (-2^(WIDTH-1)) negates without overflow.

Reset
REQ-024 Reset asserted in any state, including mid-CALC: state=IDLE, counter=0, internal x/y/z=0, magnitude=0, angle=0, busy=0, done=0.
REQ-025 After reset releases, the first start is accepted on the next edge.

Configuration
REQ-026 Macro CORDIC_GAIN_COMP_EN defined: the SCALE state multiplies x by 16'h26DD (0.60725 in Q14) and shifts right by 14, so magnitude is the true length; latency grows by one cycle.
REQ-027 Macro CORDIC_GAIN_COMP_EN undefined: there is no SCALE state, and magnitude is the raw x, i.e. length times approximately 1.64676.

Structure
REQ-028 Package cordic_pkg holds the atan(2^-i) table for i=0..30 in angle counts, the PI and PI/2 constants, CORDIC_GAIN (16'h26DD) and the FSM state enum.
REQ-029 No sub-module; single iterative datapath with one shift/add pair per axis plus the angle accumulator.

Verification (WIDTH=16, ITERATIONS=15, CORDIC_GAIN_COMP_EN defined; tolerance ±164 magnitude counts, ±5368709 angle counts)
REQ-030 x=16384, y=0 -> magnitude ~16384, angle ~0; done exactly 16 edges after the start-sampling edge.
REQ-031 x=-16384, y=0 -> angle ~+1686629713 (+pi, positive sign); x=0, y=16384 -> angle ~843314857.
REQ-032 x=11585, y=-11585 -> magnitude ~16384, angle ~-421657428; x=-32768, y=-32768 -> magnitude ~46341, angle ~-1264972285.
REQ-033 x=0, y=0 -> magnitude=0, angle=0 exactly; with macro undefined, x=16384, y=0 -> magnitude ~26981, done 15 edges after the start-sampling edge.
REQ-034 start pulsed during CALC -> ignored, single done. Reset asserted mid-CALC -> all outputs 0 and busy=0 immediately; the next start completes normally.
